// File: rtl/imem_dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction
// fetch (IF) and load/store (LS). One transaction in flight at a time:
// IDLE (grant) -> ISSUE (mem_en strobe) -> WAIT (fixed latency) -> IDLE.
module imem_dmem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  input  logic [AW-1:0]     if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DW-1:0]     if_rsp_data,
  input  logic              ls_req_valid,
  input  logic              ls_req_we,
  input  logic [AW-1:0]     ls_req_addr,
  input  logic [DW-1:0]     ls_req_wdata,
  input  logic [DW/8-1:0]   ls_req_be,
  output logic              ls_req_ready,
  output logic              ls_rsp_valid,
  output logic [DW-1:0]     ls_rsp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_be,
  input  logic [DW-1:0]     mem_rdata,
  output logic              busy
);

  localparam int unsigned CW = 4;

  // Reject latencies the 4-bit wait counter cannot represent.
  if (MEM_LAT == 0 || MEM_LAT > 15) begin : g_lat_check
    $error("imem_dmem_arbiter: MEM_LAT must be in 1..15");
  end
  if (DW % 8 != 0) begin : g_dw_check
    $error("imem_dmem_arbiter: DW must be a multiple of 8");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          last_ls;   // last grant went to LS (0 = IF)
  logic          grant_ls;  // current transaction belongs to LS
  logic          req_we;    // current transaction is a write
  logic          accept;
  logic          sel_ls;

  // Next-state, grant selection, request handshake and response routing.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    accept       = 1'b0;
    sel_ls       = 1'b0;
    if_req_ready = 1'b0;
    ls_req_ready = 1'b0;
    if_rsp_valid = 1'b0;
    ls_rsp_valid = 1'b0;
    if_rsp_data  = '0;
    ls_rsp_data  = '0;
    case (state)
      IDLE: begin
        if (if_req_valid || ls_req_valid) begin
          accept       = 1'b1;
          sel_ls       = ls_req_valid && (!if_req_valid || !last_ls);
          ls_req_ready = sel_ls;
          if_req_ready = !sel_ls;
          state_next   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = CW'(MEM_LAT);
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt == CW'(1)) begin
          if (grant_ls) begin
            ls_rsp_valid = 1'b1;
            ls_rsp_data  = req_we ? '0 : mem_rdata;
          end else begin
            if_rsp_valid = 1'b1;
            if_rsp_data  = mem_rdata;
          end
          state_next = IDLE;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    // Nothing is accepted or returned while reset is held.
    if (reset) begin
      accept       = 1'b0;
      if_req_ready = 1'b0;
      ls_req_ready = 1'b0;
      if_rsp_valid = 1'b0;
      ls_rsp_valid = 1'b0;
      if_rsp_data  = '0;
      ls_rsp_data  = '0;
    end
  end

  // State, counter, grant history and registered memory port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      last_ls   <= 1'b0;
      grant_ls  <= 1'b0;
      req_we    <= 1'b0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      busy   <= (state_next != IDLE);
      mem_en <= accept;
      mem_we <= accept && sel_ls && ls_req_we;
      if (accept) begin
        last_ls   <= sel_ls;
        grant_ls  <= sel_ls;
        req_we    <= sel_ls && ls_req_we;
        mem_addr  <= sel_ls ? ls_req_addr : if_req_addr;
        mem_wdata <= sel_ls ? ls_req_wdata : '0;
        mem_be    <= sel_ls ? ls_req_be : '1;
      end
    end
  end

endmodule
